// File: rtl/pe_ctrl_pkg.sv
// pe_ctrl_pkg: shared state encoding, default sizes and PE strobe bundle for the PE sequencer
package pe_ctrl_pkg;
  localparam int CNT_W_DEF = 10;
  localparam int CHAIN_LEN_DEF = 4;
  localparam int CHAIN_W_DEF = 3;
  typedef enum logic [2:0] {
    S_IDLE,
    S_PRELOAD,
    S_BIAS,
    S_MAC,
    S_MERGE,
    S_SHIFT,
    S_DONE
  } state_t;
  typedef struct packed {
    logic gate_en;
    logic wea_reg1;
    logic wea_reg2;
    logic shift;
    logic load_bias;
    logic load_psum;
    logic sel_pe_reg;
    logic rst_pe_relu_reg;
    logic if_relu;
  } pe_strb_t;
endpackage

// File: rtl/pe_seq_ctrl_if.sv
// pe_seq_ctrl_if: scheduler job handshake plus PE strobe fan-out bundle
interface pe_seq_ctrl_if #(parameter int CNT_W = pe_ctrl_pkg::CNT_W_DEF) ();
  import pe_ctrl_pkg::*;
  logic start;
  logic [CNT_W-1:0] num_mac;
  logic relu_en;
  logic merge_en;
  logic abort;
  logic busy;
  logic done;
  logic op_req;
  logic out_valid;
  pe_strb_t strb;
  modport master (
    output start, num_mac, relu_en, merge_en, abort,
    input busy, done, op_req, out_valid, strb
  );
  modport slave (
    input start, num_mac, relu_en, merge_en, abort,
    output busy, done, op_req, out_valid, strb
  );
endinterface

// File: rtl/pe_seq_cnt.sv
// pe_seq_cnt: loadable down-counter that stops at zero and flags terminal count
module pe_seq_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         tc
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && !tc) cnt <= cnt - 1'b1;
  assign tc = cnt == '0;
endmodule

// File: rtl/pe_seq_ctrl.sv
// pe_seq_ctrl: PE job sequencer (preload/bias/MAC/merge/shift-out); PE_SEQ_CTRL_PERF_EN adds perf_cycles
module pe_seq_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int CHAIN_W = CHAIN_W_DEF
) (
  input logic clk,
  input logic reset,
  pe_seq_ctrl_if.slave bus
`ifdef PE_SEQ_CTRL_PERF_EN
  ,
  output logic [31:0] perf_cycles
`endif
);
  localparam logic [CHAIN_W-1:0] CH_LAST = CHAIN_W'(CHAIN_LEN - 1);
  state_t st, st_nx, post_mac;
  logic relu_q, merge_q, mac_tc, ch_tc, accept;
  pe_strb_t strb;
  assign accept = st == S_IDLE && bus.start && !bus.abort;
  assign post_mac = merge_q ? S_MERGE : S_SHIFT;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st <= S_IDLE;
      relu_q <= 1'b0;
      merge_q <= 1'b0;
    end else begin
      st <= st_nx;
      if (accept) begin
        relu_q <= bus.relu_en;
        merge_q <= bus.merge_en;
      end
    end
  // MAC counter holds num_mac at BIAS and reaches zero on the last MAC cycle
  pe_seq_cnt #(.W(CNT_W)) u_mac (
    .clk(clk), .reset(reset), .load(accept), .en(st == S_BIAS || st == S_MAC),
    .load_val(bus.num_mac), .tc(mac_tc)
  );
  pe_seq_cnt #(.W(CHAIN_W)) u_chain (
    .clk(clk), .reset(reset), .load(!(st == S_PRELOAD || st == S_SHIFT)), .en(1'b1),
    .load_val(CH_LAST), .tc(ch_tc)
  );
  always_comb begin
    st_nx = S_IDLE;
    case (st)
      S_IDLE:    st_nx = accept ? (bus.merge_en ? S_PRELOAD : S_BIAS) : S_IDLE;
      S_PRELOAD: st_nx = ch_tc ? S_BIAS : S_PRELOAD;
      S_BIAS:    st_nx = mac_tc ? post_mac : S_MAC;
      S_MAC:     st_nx = mac_tc ? post_mac : S_MAC;
      S_MERGE:   st_nx = S_SHIFT;
      S_SHIFT:   st_nx = ch_tc ? S_DONE : S_SHIFT;
      default:   st_nx = S_IDLE;
    endcase
    if (bus.abort) st_nx = S_IDLE;
    strb = '0;
    strb.gate_en = st == S_BIAS || (st == S_MAC && !mac_tc);
    strb.wea_reg1 = st inside {S_BIAS, S_MAC, S_MERGE, S_SHIFT};
    strb.wea_reg2 = st == S_PRELOAD;
    strb.shift = st inside {S_PRELOAD, S_SHIFT};
    strb.load_bias = st == S_BIAS;
    strb.load_psum = st == S_MERGE;
    strb.sel_pe_reg = st == S_PRELOAD;
    strb.rst_pe_relu_reg = !(st == S_MERGE || (st == S_MAC && mac_tc && !merge_q));
    strb.if_relu = st != S_IDLE && relu_q;
  end
  assign bus.strb = strb;
  assign bus.busy = st != S_IDLE;
  assign bus.done = st == S_DONE;
  assign bus.op_req = strb.gate_en;
  assign bus.out_valid = st == S_SHIFT;
`ifdef PE_SEQ_CTRL_PERF_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) perf_cycles <= '0;
    else if (accept) perf_cycles <= '0;
    else if (st != S_IDLE && perf_cycles != '1) perf_cycles <= perf_cycles + 1'b1;
`endif
endmodule

// File: tb/tb_pe_seq_ctrl.sv
// tb_pe_seq_ctrl: directed jobs against a behavioural PE row, checked by data and timing scoreboards
module tb_pe_seq_ctrl;
  import pe_ctrl_pkg::*;
  localparam int CL = 4;
  typedef struct {
    int busy;
    int outv;
    int sel;
    int wea2;
    int gate;
  } tim_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  pe_seq_ctrl_if #(.CNT_W(10)) bus ();
  pe_seq_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  int compared = 0;
  int mismatched = 0;
  int data_q[$];
  tim_t tim_q[$];
  int ia_q[$], wgt_q[$];
  int bias = 0, psum_in = 0, ia = 0, wgt = 0;
  int a_q, w_q;
  int reg1[CL], reg2[CL];
  pe_strb_t idle_strb;
  tim_t t;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int pe_wr(input int cur, input int r2);
    int nv;
    nv = bus.strb.load_bias ? bias : bus.strb.load_psum ? cur + r2 : cur + a_q * w_q;
    return (bus.strb.if_relu && !bus.strb.rst_pe_relu_reg && nv < 0) ? 0 : nv;
  endfunction

  // row of CL lock-stepped PEs sharing the broadcast strobes and operands
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q <= 0;
      w_q <= 0;
      for (int k = 0; k < CL; k++) begin
        reg1[k] <= 0;
        reg2[k] <= 0;
      end
    end else begin
      if (bus.strb.gate_en) begin
        a_q <= ia;
        w_q <= wgt;
      end
      if (bus.strb.shift && bus.strb.sel_pe_reg && bus.strb.wea_reg2) begin
        reg2[0] <= psum_in;
        for (int k = 1; k < CL; k++) reg2[k] <= reg2[k-1];
      end
      if (bus.strb.wea_reg1) begin
        if (bus.strb.shift && !bus.strb.sel_pe_reg) begin
          reg1[0] <= 0;
          for (int k = 1; k < CL; k++) reg1[k] <= reg1[k-1];
        end else begin
          for (int k = 0; k < CL; k++) reg1[k] <= pe_wr(reg1[k], reg2[k]);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (bus.op_req) begin
      if (ia_q.size() > 0) begin
        ia = ia_q.pop_front();
        wgt = wgt_q.pop_front();
      end else begin
        ia = 0;
        wgt = 0;
      end
    end
  end

  initial begin
    int bc, oc, sc, wc, gc, rc;
    bc = 0; oc = 0; sc = 0; wc = 0; gc = 0; rc = 0;
    forever begin
      @(negedge clk);
      if (bus.out_valid) begin
        if (data_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL data: unexpected out_valid, tail=%0d", reg1[CL-1]);
        end else chk("data", reg1[CL-1], data_q.pop_front());
      end
      if (bus.busy) begin
        bc++;
        if (bus.out_valid) oc++;
        if (bus.strb.sel_pe_reg) sc++;
        if (bus.strb.wea_reg2) wc++;
        if (bus.strb.gate_en) gc++;
        if (bus.op_req) rc++;
      end
      if (bus.done) begin
        if (tim_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL done: unexpected done pulse after %0d busy cycles", bc);
        end else begin
          t = tim_q.pop_front();
          chk("busy_len", bc, t.busy);
          chk("out_valid_cycles", oc, t.outv);
          chk("sel_pe_reg_cycles", sc, t.sel);
          chk("wea_reg2_cycles", wc, t.wea2);
          chk("gate_en_cycles", gc, t.gate);
          chk("op_req_cycles", rc, t.gate);
        end
      end
      if (!bus.busy) begin
        bc = 0; oc = 0; sc = 0; wc = 0; gc = 0; rc = 0;
      end
    end
  end

  task automatic push_ops(input int a, input int w);
    ia_q.push_back(a);
    wgt_q.push_back(w);
  endtask

  task automatic expect_job(input int res, input int busy_len, input int gates, input bit merge);
    repeat (CL) data_q.push_back(res);
    tim_q.push_back('{busy_len, CL, merge ? CL : 0, merge ? CL : 0, gates});
  endtask

  task automatic launch(input int n, input bit relu, input bit merge, input int b, input int p);
    @(negedge clk);
    bus.num_mac = 10'(n);
    bus.relu_en = relu;
    bus.merge_en = merge;
    bias = b;
    psum_in = p;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!bus.done && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!bus.done) begin
      compared++;
      mismatched++;
      $display("FAIL wait_done: no done within %0d cycles", k);
    end
  endtask

  initial begin
    int k, v;
    idle_strb = '0;
    idle_strb.rst_pe_relu_reg = 1'b1;
    bus.start = 1'b0;
    bus.num_mac = '0;
    bus.relu_en = 1'b0;
    bus.merge_en = 1'b0;
    bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_strb", int'(bus.strb), int'(idle_strb));
    reset = 1'b1;
    // basic MAC: 5 + 6 - 4 + 1
    push_ops(2, 3); push_ops(-1, 4); push_ops(1, 1);
    expect_job(8, 9, 3, 0);
    launch(3, 0, 0, 5, 0);
    wait_done();
    // ReLU clamps the final -8
    push_ops(1, 2);
    expect_job(0, 7, 1, 0);
    launch(1, 1, 0, -10, 0);
    wait_done();
    // intermediate -11 must survive to give 4
    push_ops(-1, 1); push_ops(3, 5);
    expect_job(4, 8, 2, 0);
    launch(2, 1, 0, -10, 0);
    wait_done();
    // merge: 1 + 4 + 7 with two zero MACs
    push_ops(2, 2); push_ops(0, 0); push_ops(0, 0);
    expect_job(12, 14, 3, 1);
    launch(3, 0, 1, 1, 7);
    wait_done();
    // num_mac=0: bias is final, no ReLU
    expect_job(-3, 6, 1, 0);
    launch(0, 1, 0, -3, 0);
    wait_done();
    // abort in MAC cycle 1, then immediate restart
    launch(5, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_mac", int'(bus.strb.wea_reg1 && !bus.strb.load_bias), 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_out_valid", int'(bus.out_valid), 0);
    chk("abort_strb", int'(bus.strb), int'(idle_strb));
    push_ops(3, 3);
    expect_job(11, 7, 1, 0);
    bus.num_mac = 10'd1;
    bus.relu_en = 1'b0;
    bus.merge_en = 1'b0;
    bias = 2;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("restart_busy", int'(bus.busy), 1);
    wait_done();
    // start held high across a job, reset mid-SHIFT of the second
    repeat (2) begin
      push_ops(2, 3); push_ops(-1, 4); push_ops(1, 1);
    end
    expect_job(8, 9, 3, 0);
    @(negedge clk);
    bus.num_mac = 10'd3;
    bias = 5;
    psum_in = 0;
    bus.start = 1'b1;
    wait_done();
    repeat (2) data_q.push_back(8);
    @(negedge clk);
    chk("held_start_gap_busy", int'(bus.busy), 0);
    k = 0;
    v = 0;
    while (v < 2 && k < 50) begin
      @(negedge clk);
      k++;
      if (bus.out_valid) v++;
    end
    chk("second_job_shift_reached", v, 2);
    #1 reset = 1'b0;
    #1;
    chk("async_reset_busy", int'(bus.busy), 0);
    chk("async_reset_done", int'(bus.done), 0);
    chk("async_reset_out_valid", int'(bus.out_valid), 0);
    chk("async_reset_strb", int'(bus.strb), int'(idle_strb));
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("data_left", data_q.size(), 0);
    chk("timing_left", tim_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
